// File: rtl/alu_exec_stage.sv
// Execute stage: NZCV ALU with condition evaluation against the architectural flags,
// feeding a 2-entry skid buffer so writeback stalls never drop an operation.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_ctrl,
  input  logic [3:0]       in_cond,
  input  logic             in_setf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_exec,
  output logic [3:0]       flags_q
);

  localparam int ENTRY_W = WIDTH + 5;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic signed [WIDTH-1:0] res_p0;
  logic        [WIDTH:0]   sum_p0;
  logic                    c_p0;
  logic                    v_p0;
  logic        [3:0]       nzcv_p0;
  logic                    pass_p0;
  logic                    vld_p0;
  logic                    pop;
  logic        [ENTRY_W-1:0] entry_p0;
  logic        [ENTRY_W-1:0] buf_p1 [2];
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic        [1:0]       count;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c & !z;
      4'b1001: cond_pass = !c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // Stage p0: combinational ALU and condition check in the accept cycle
  always_comb begin
    a_p0   = in_a;
    b_p0   = in_b;
    sum_p0 = '0;
    res_p0 = '0;
    c_p0   = 1'b0;
    v_p0   = 1'b0;
    case (in_ctrl)
      2'b00: begin
        sum_p0 = {1'b0, in_a} + {1'b0, in_b};
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (res_p0[WIDTH-1] != a_p0[WIDTH-1]);
      end
      2'b01: begin
        // SUB as A + ~B + 1, so carry-out is the inverted borrow
        sum_p0 = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (res_p0[WIDTH-1] != a_p0[WIDTH-1]);
      end
      2'b10:   res_p0 = a_p0 & b_p0;
      default: res_p0 = a_p0 | b_p0;
    endcase
    nzcv_p0  = {res_p0[WIDTH-1], (res_p0 == '0), c_p0, v_p0};
    pass_p0  = cond_pass(in_cond, flags_q);
    entry_p0 = {res_p0, nzcv_p0, pass_p0};
  end

  assign vld_p0    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign {out_result, out_flags, out_exec} = buf_p1[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (vld_p0 && pass_p0 && in_setf) begin
      flags_q <= nzcv_p0;
    end
  end

  // Stage p1: skid buffer, circular over two slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) buf_p1[i] <= '0;
    end else begin
      if (vld_p0) begin
        buf_p1[wr_ptr] <= entry_p0;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({vld_p0, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed plus short random bench for alu_exec_stage with an in-order scoreboard.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_ctrl;
  logic [3:0]  in_cond;
  logic        in_setf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_exec;
  logic [3:0]  flags_q;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_cond(in_cond), .in_setf(in_setf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_exec(out_exec),
    .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  f;
    logic        ex;
  } exp_t;

  exp_t     sb[$];
  logic [3:0] m_flags;
  int       checks;
  int       errors;
  int       pop_cnt;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_OP = 2'b10, OR_OP = 2'b11;
  localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, GE = 4'b1010, LT = 4'b1011, AL = 4'b1110;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic [31:0] r;
    logic        c, v;
    longint      s;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ADD: begin
        r = a + b;
        c = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      SUB: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      AND_OP:  r = a & b;
      default: r = a | b;
    endcase
    m_alu = {r, r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic m_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  m_cond = z;
      4'd1:  m_cond = ~z;
      4'd2:  m_cond = c;
      4'd3:  m_cond = ~c;
      4'd4:  m_cond = n;
      4'd5:  m_cond = ~n;
      4'd6:  m_cond = v;
      4'd7:  m_cond = ~v;
      4'd8:  m_cond = c && !z;
      4'd9:  m_cond = !c || z;
      4'd10: m_cond = (n ~^ v);
      4'd11: m_cond = (n ^ v);
      4'd12: m_cond = !z && (n ~^ v);
      4'd13: m_cond = z || (n ^ v);
      default: m_cond = 1'b1;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [3:0] cc, input logic sf);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_ctrl  = op;
    in_cond  = cc;
    in_setf  = sf;
  endtask

  // Called at a negedge: check, update model for the coming posedge, advance one cycle.
  task automatic tick();
    logic       acc, pp, pass;
    logic [35:0] r;
    exp_t       e;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    chk("in_ready", in_ready, sb.size() < 2);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("flags_q", flags_q, m_flags);
    if (pp && sb.size() != 0) begin
      e = sb.pop_front();
      chk("head", {out_result, out_flags, out_exec}, e);
      pop_cnt++;
    end
    if (acc) begin
      r    = m_alu(in_a, in_b, in_ctrl);
      pass = m_cond(in_cond, m_flags);
      sb.push_back({r, pass});
      if (pass && in_setf) m_flags = r[3:0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    int n0;
    logic [31:0] held;
    checks = 0; errors = 0; pop_cnt = 0;
    m_flags = 4'b0000;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, ADD, AL, 1'b0);

    // Reset asserted between edges, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flags", flags_q, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out", {out_result, out_flags, out_exec}, 37'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed overflow on ADD
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, ADD, AL, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, ADD, AL, 1'b0);
    chk("ovf_result", out_result, 32'h8000_0000);
    chk("ovf_flags", out_flags, 4'b1001);
    tick();
    chk("ovf_flags_q", flags_q, 4'b1001);

    // Back-to-back flag dependency
    drive(1'b1, 32'd5, 32'd5, SUB, AL, 1'b1);  tick();
    drive(1'b1, 32'd1, 32'd1, ADD, EQ, 1'b0);  tick();
    chk("dep_flags_q", flags_q, 4'b0110);
    drive(1'b1, 32'd1, 32'd1, ADD, NE, 1'b1);  tick();
    drive(1'b0, 32'd0, 32'd0, ADD, AL, 1'b0);
    chk("ne_exec", out_exec, 1'b0);
    chk("ne_flags_q", flags_q, 4'b0110);
    drain(6);

    // Backpressure: three offered, two accepted, head held
    out_ready = 1'b0;
    drive(1'b1, 32'hF0F0_00FF, 32'h0FF0_0F0F, AND_OP, AL, 1'b0); tick();
    drive(1'b1, 32'h1234_0000, 32'h0000_5678, OR_OP, AL, 1'b0);  tick();
    chk("full_in_ready", in_ready, 1'b0);
    held = out_result;
    drive(1'b1, 32'd9, 32'd3, SUB, AL, 1'b0); tick();
    chk("held_result", out_result, 32'h00F0_000F);
    chk("held_stable", out_result, held);
    chk("accepted_two", sb.size(), 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n0 = 0;
    while (sb.size() != 0 && n0 < 6) begin tick(); n0++; end
    chk("drain_cycles", n0, 2);

    // Full buffer released with pushes every cycle
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd1, ADD, AL, 1'b0); tick();
    drive(1'b1, 32'd20, 32'd2, ADD, AL, 1'b0); tick();
    out_ready = 1'b1;
    n0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd100 + i, 32'd7, SUB, AL, 1'b1);
      tick();
    end
    chk("tput_pops", pop_cnt - n0, 4);
    drain(6);

    // Random mix under random backpressure
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, (i % 5 == 0) ? 32'd0 : $urandom,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (i % 7 == 3) in_b = in_a;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(6);

    // Reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, SUB, AL, 1'b1); tick();
    drive(1'b1, 32'd1, 32'd2, ADD, AL, 1'b0);         tick();
    chk("pre_rst_flags", flags_q, 4'b1010);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_flags", flags_q, 4'b0000);
    chk("midrst_in_ready", in_ready, 1'b1);
    sb.delete();
    m_flags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'd3, 32'd4, ADD, GE, 1'b0); tick();
    drive(1'b1, 32'd3, 32'd4, ADD, LT, 1'b0); tick();
    in_valid = 1'b0;
    chk("post_rst_lt_exec", out_exec, 1'b0);
    drain(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
